// File: rtl/traffic_field.sv
// Rotating car-occupancy field for the Frogger LED matrix: ROWS lanes of COLS cells,
// each lane stepping on a divided base tick whose period shrinks with the game level.
module traffic_field #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned COLS        = 8,
  parameter int unsigned DIV_W       = 28,
  parameter int unsigned BASE_PERIOD = 75000000,
  parameter int unsigned MIN_PERIOD  = 2,
  parameter int unsigned LEVEL_W     = 4,
  parameter int unsigned SPD_W       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [ROWS*COLS-1:0]     patterns,
  input  logic [ROWS-1:0]          moving_right,
  input  logic [ROWS*SPD_W-1:0]    row_speed,
  input  logic                     pause,
  input  logic                     level_up,
  input  logic                     level_clr,
  output logic [ROWS*COLS-1:0]     cars,
  output logic                     tick,
  output logic [LEVEL_W-1:0]       level
);

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = '1;

  logic [DIV_W-1:0]   shifted;
  logic [DIV_W-1:0]   period;
  logic [DIV_W-1:0]   cnt;
  logic [LEVEL_W-1:0] level_next;
  logic               level_chg;
  logic               fire;

  // Tick period halves per level, floored so the counter always has at least two states.
  always_comb begin
    shifted = DIV_W'(BASE_PERIOD) >> level;
    period  = (shifted < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : shifted;
  end

  always_comb begin
    level_next = level;
    if (level_clr)
      level_next = '0;
    else if (level_up && (level != MAX_LEVEL))
      level_next = level + LEVEL_W'(1);
    level_chg = (level_next != level);
    fire      = !load && !pause && !level_chg && (cnt == period - DIV_W'(1));
  end

  // Base counter, tick and level; a level change restarts the count under the new period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      tick  <= 1'b0;
      level <= '0;
    end else begin
      level <= level_next;
      tick  <= fire;
      if (load || level_chg)
        cnt <= '0;
      else if (!pause)
        cnt <= (cnt == period - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [COLS-1:0]  row_q;
    logic [COLS-1:0]  row_rot;
    logic [SPD_W-1:0] sub;
    logic [SPD_W-1:0] speed;

    assign speed   = row_speed[r*SPD_W +: SPD_W];
    assign row_rot = moving_right[r] ? {row_q[COLS-2:0], row_q[COLS-1]}
                                     : {row_q[0], row_q[COLS-1:1]};

    // Sub-counter wraps through its full range when speed drops below it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        row_q <= '0;
        sub   <= '0;
      end else if (load) begin
        row_q <= patterns[r*COLS +: COLS];
        sub   <= '0;
      end else if (fire) begin
        if (sub == speed) begin
          row_q <= row_rot;
          sub   <= '0;
        end else begin
          sub <= sub + SPD_W'(1);
        end
      end
    end

    assign cars[r*COLS +: COLS] = row_q;
  end

endmodule
